button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Receiving end of the watch's four-button user interface: conditions raw mechanical button lines into clean, single-cycle events for the time-setting logic.
- Per button: synchronisation, debouncing, press and release edge pulses, long-press detection and auto-repeat.
- Sits between the board/bench button inputs and the clock-setting controller. All four channels are identical and fully independent.

Parameters:
- DEBOUNCE_CYCLES, 500: consecutive stable clock cycles required before the debounced level changes (legal range ≥2).
- HOLD_CYCLES, 10000: cycles of debounced-high level before the long-press pulse fires (must be > DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 2000: period of auto-repeat pulses after a long press (≥2).

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset; the block runs while reset=1.
- button, input, [0:3]: raw button lines, active-high, asynchronous to clock, may bounce.
- btn_level, output, [0:3]: debounced level per button.
- btn_press, output, [0:3]: 1-cycle pulse on debounced rising edge.
- btn_release, output, [0:3]: 1-cycle pulse on debounced falling edge.
- btn_long, output, [0:3]: 1-cycle pulse when a press reaches HOLD_CYCLES.
- btn_repeat, output, [0:3]: 1-cycle pulse every REPEAT_CYCLES after btn_long while still held.
- btn_any_press, output, 1: OR of btn_press[0:3], same cycle.

Behaviour:
- Reset (reset=0, asynchronous): synchronizer flops, debounce counters, hold counters and all outputs cleared to 0. Every FSM goes to IDLE.
- Synchronizer: 2 flops per button. sync[i] lags button[i] by 2 clocks.
- Per-button FSM states:
  - IDLE (level 0).
  - DB_RISE (level 0, counting).
  - PRESSED (level 1, before long).
  - HELD (level 1, long reached).
  - DB_FALL (level 1, counting).
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- IDLE: sync=1 moves to DB_RISE with counter=1.
- DB_RISE:
  - sync=0 returns to IDLE and clears the counter (bounce restarts qualification).
  - sync=1 with counter=DEBOUNCE_CYCLES-1 moves to PRESSED. btn_level rises and btn_press pulses in that same cycle.
  - Otherwise the counter increments.
- Latency: a clean edge on button at cycle 0 (sampled) gives btn_level/btn_press at cycle DEBOUNCE_CYCLES+2.
- Hold counter:
  - Width is $clog2(HOLD_CYCLES+1). It is cleared on entry to PRESSED and increments each cycle while btn_level=1.
  - When it equals HOLD_CYCLES-1 the FSM moves to PRESSED→HELD and btn_long pulses.
  - In HELD, a separate repeat counter runs with period REPEAT_CYCLES. btn_repeat pulses when it wraps from REPEAT_CYCLES-1 to 0. The first repeat fires REPEAT_CYCLES cycles after btn_long.
  - The hold counter saturates; no other wrap-around is permitted.
- PRESSED or HELD: sync=0 moves to DB_FALL with counter=1.
- DB_FALL:
  - sync=1 returns to the originating state (PRESSED or HELD, tracked by a flag). Hold and repeat counts keep advancing during the bounce; no events are lost or duplicated.
  - sync=0 with counter=DEBOUNCE_CYCLES-1 moves to IDLE. btn_level falls, btn_release pulses, and the hold/repeat counters clear.
- Pulse exclusivity:
  - btn_press and btn_release are never asserted together on one channel.
  - btn_long and btn_repeat never coincide.
  - No btn_long or btn_repeat fires in a cycle where the release is being committed, or later.
- Simultaneous presses on several buttons: each channel is evaluated independently. Pulses may coincide across channels, and btn_any_press is asserted once.
- Button held through reset deassertion: it is treated as a fresh press, with btn_press after DEBOUNCE_CYCLES+2 cycles.
- Reset asserted mid-press or mid-debounce: outputs drop to 0 immediately, with no release pulse.
- All outputs are registered. There is no combinational path from button to any output.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5):
- Reset/idle: reset=0 with button=4'b0001 → all outputs 0. Release reset, hold button[3]=1 → btn_press[3] pulses exactly 6 cycles after the first sampled edge, and btn_level[3]=1.
- Bounce: button[1] toggles 1,0,1,0 every cycle, then stays 1 → no pulse during the bounce. One btn_press[1] arrives 6 cycles after the final rising edge.
- Short press: button[2]=1 for 10 cycles, then 0 → one btn_press[2], one btn_release[2] 10 cycles after the press pulse, and no btn_long.
- Long press with repeat: button[0]=1 for 40 cycles → btn_press[0], then btn_long[0] 20 cycles later, then btn_repeat[0] at +5 and +10 after it. A release in the middle of a repeat period gives btn_release[0] and no further repeats.
- Simultaneous presses: button[0] and button[2] rise on the same cycle → btn_press[0] and btn_press[2] in the same cycle, with one btn_any_press.
- Reset mid-hold: assert reset during HELD on button[3] → btn_level[3]=0 asynchronously with no btn_release. After release of reset with the button still high, a fresh btn_press[3] arrives after 6 cycles.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button bundle: raw button lines in, conditioned per-button level and event pulses out.
// The board/bench side uses master; the conditioner uses slave.
interface button_conditioner_if;
  logic [0:3] button;
  logic [0:3] btn_level;
  logic [0:3] btn_press;
  logic [0:3] btn_release;
  logic [0:3] btn_long;
  logic [0:3] btn_repeat;
  logic       btn_any_press;

  modport master (
    output button,
    input  btn_level, btn_press, btn_release, btn_long, btn_repeat, btn_any_press
  );

  modport slave (
    input  button,
    output btn_level, btn_press, btn_release, btn_long, btn_repeat, btn_any_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Four independent button channels: 2-flop sync, debounce FSM, press/release edges,
// long-press detection and auto-repeat. All outputs are registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int HOLD_CYCLES     = 10000,
  parameter int REPEAT_CYCLES   = 2000
) (
  input  logic                clock,
  input  logic                reset,
  button_conditioner_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DB_RISE, PRESSED, HELD, DB_FALL} state_t;

  logic [0:3] r_sync1, r_sync2;
  logic [0:3] w_level, w_press, w_release, w_long, w_repeat;
  logic [0:3] r_level, r_press, r_release, r_long, r_repeat;
  logic       r_any;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    state_t        r_state, w_state;
    logic [DW-1:0] r_db, w_db;
    logic [HW-1:0] r_hold, w_hold;
    logic [RW-1:0] r_rep, w_rep;
    logic          r_fromHeld, w_fromHeld;
    logic          w_sync, w_commit, w_inHold, w_inRep, w_levelNow;
    logic          w_isPress, w_isRelease, w_isLong, w_isRepeat;

    assign w_sync = r_sync2[g];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_state    <= IDLE;
        r_db       <= '0;
        r_hold     <= '0;
        r_rep      <= '0;
        r_fromHeld <= 1'b0;
      end else begin
        r_state    <= w_state;
        r_db       <= w_db;
        r_hold     <= w_hold;
        r_rep      <= w_rep;
        r_fromHeld <= w_fromHeld;
      end
    end

    // Long/repeat keep running through a falling bounce but are suppressed once the release commits.
    always_comb begin
      w_state     = r_state;
      w_db        = r_db;
      w_hold      = r_hold;
      w_rep       = r_rep;
      w_fromHeld  = r_fromHeld;
      w_isPress   = 1'b0;
      w_isRelease = 1'b0;
      w_levelNow  = (r_state == PRESSED) || (r_state == HELD) || (r_state == DB_FALL);
      w_commit    = (r_state == DB_FALL) && !w_sync && (r_db == DB_LAST);
      w_inHold    = (r_state == PRESSED) || ((r_state == DB_FALL) && !r_fromHeld);
      w_inRep     = (r_state == HELD) || ((r_state == DB_FALL) && r_fromHeld);
      w_isLong    = w_inHold && (r_hold == HOLD_LAST) && !w_commit;
      w_isRepeat  = w_inRep && (r_rep == REP_LAST) && !w_commit;

      if (w_levelNow && (r_hold != HOLD_LAST)) w_hold = r_hold + HW'(1);
      if (w_inRep) w_rep = (r_rep == REP_LAST) ? '0 : r_rep + RW'(1);
      if (w_isLong) begin
        w_fromHeld = 1'b1;
        w_rep      = '0;
      end

      case (r_state)
        IDLE: begin
          if (w_sync) begin
            w_state = DB_RISE;
            w_db    = DW'(1);
          end
        end
        DB_RISE: begin
          if (!w_sync) begin
            w_state = IDLE;
            w_db    = '0;
          end else if (r_db == DB_LAST) begin
            w_state    = PRESSED;
            w_db       = '0;
            w_hold     = '0;
            w_rep      = '0;
            w_fromHeld = 1'b0;
            w_isPress  = 1'b1;
          end else begin
            w_db = r_db + DW'(1);
          end
        end
        PRESSED: begin
          if (!w_sync) begin
            w_state = DB_FALL;
            w_db    = DW'(1);
          end else if (w_isLong) begin
            w_state = HELD;
          end
        end
        HELD: begin
          if (!w_sync) begin
            w_state = DB_FALL;
            w_db    = DW'(1);
          end
        end
        DB_FALL: begin
          if (w_sync) begin
            w_state = w_fromHeld ? HELD : PRESSED;
            w_db    = '0;
          end else if (w_commit) begin
            w_state     = IDLE;
            w_db        = '0;
            w_hold      = '0;
            w_rep       = '0;
            w_fromHeld  = 1'b0;
            w_isRelease = 1'b1;
          end else begin
            w_db = r_db + DW'(1);
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end

    assign w_level[g]   = (w_state == PRESSED) || (w_state == HELD) || (w_state == DB_FALL);
    assign w_press[g]   = w_isPress;
    assign w_release[g] = w_isRelease;
    assign w_long[g]    = w_isLong;
    assign w_repeat[g]  = w_isRepeat;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_repeat  <= '0;
      r_any     <= 1'b0;
    end else begin
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
      r_long    <= w_long;
      r_repeat  <= w_repeat;
      r_any     <= |w_press;
    end
  end

  assign bus.btn_level     = r_level;
  assign bus.btn_press     = r_press;
  assign bus.btn_release   = r_release;
  assign bus.btn_long      = r_long;
  assign bus.btn_repeat    = r_repeat;
  assign bus.btn_any_press = r_any;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat periods so every
// corner fits in a few dozen cycles; cycle k means k rising edges after the stimulus started.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clock;
  logic reset;
  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [0:3] button;
    logic [0:3] level;
    logic [0:3] press;
    logic [0:3] rel;
    logic [0:3] lng;
    logic [0:3] rpt;
    logic       any;
  } vec_t;

  vec_t table_q[20];
  int checks = 0;
  int errors = 0;

  int pressAt[4], releaseAt[4], longAt[4];
  int pressCnt[4], releaseCnt[4], longCnt[4], repeatCnt[4];
  int repeatAt[$];
  int anyCnt, vio;

  function automatic vec_t mk(input logic [0:3] b, input logic [0:3] l, input logic [0:3] p,
                              input logic [0:3] r, input logic a);
    vec_t v;
    v.button = b;
    v.level  = l;
    v.press  = p;
    v.rel    = r;
    v.lng    = 4'b0000;
    v.rpt    = 4'b0000;
    v.any    = a;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [0:3] b);
    bus.button = b;
  endtask

  task automatic checkOutput(input string name, input vec_t e);
    logic [20:0] act, exp;
    act = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long, bus.btn_repeat,
           bus.btn_any_press};
    exp = {e.level, e.press, e.rel, e.lng, e.rpt, e.any};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (level,press,release,long,repeat,any)",
               name, act, exp);
    end
  endtask

  // Drives mask on the cycles where pattern has a 1 and records when each pulse shows up.
  task automatic observe(input int n, input logic [0:3] mask, input logic [63:0] pattern);
    for (int c = 0; c < 4; c++) begin
      pressAt[c] = -1; releaseAt[c] = -1; longAt[c] = -1;
      pressCnt[c] = 0; releaseCnt[c] = 0; longCnt[c] = 0; repeatCnt[c] = 0;
    end
    repeatAt.delete();
    anyCnt = 0;
    vio = 0;
    applyStimulus(pattern[0] ? mask : 4'b0000);
    for (int k = 1; k <= n; k++) begin
      @(posedge clock);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (bus.btn_press[c]) begin pressCnt[c]++; if (pressAt[c] < 0) pressAt[c] = k; end
        if (bus.btn_release[c]) begin releaseCnt[c]++; if (releaseAt[c] < 0) releaseAt[c] = k; end
        if (bus.btn_long[c]) begin longCnt[c]++; if (longAt[c] < 0) longAt[c] = k; end
        if (bus.btn_repeat[c]) begin repeatCnt[c]++; repeatAt.push_back(k); end
        if ((bus.btn_press[c] && bus.btn_release[c]) || (bus.btn_long[c] && bus.btn_repeat[c]))
          vio++;
      end
      if (bus.btn_any_press) anyCnt++;
      if (k < 64) applyStimulus(pattern[k] ? mask : 4'b0000);
    end
  endtask

  task automatic settle();
    applyStimulus(4'b0000);
    repeat (12) @(posedge clock);
    #1;
  endtask

  initial begin
    // Short press on button[2]: row j drives period j and checks the outputs one edge later.
    for (int j = 0; j < 5; j++)   table_q[j] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    table_q[5] = mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b1);
    for (int j = 6; j < 10; j++)  table_q[j] = mk(4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    for (int j = 10; j < 15; j++) table_q[j] = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    table_q[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    for (int j = 16; j < 20; j++) table_q[j] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    bus.button = 4'b0001;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_outputs", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));

    reset = 1'b1;
    observe(10, 4'b0001, '1);
    check("held_reset_press_cycle", pressAt[3], 6);
    check("held_reset_press_count", pressCnt[3], 1);
    check("held_reset_level", int'(bus.btn_level[3]), 1);
    check("held_reset_other_press", pressCnt[0] + pressCnt[1] + pressCnt[2], 0);
    settle();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(table_q[i].button);
      @(posedge clock);
      #1;
      checkOutput($sformatf("short_press_row%0d", i), table_q[i]);
    end

    observe(20, 4'b0100, 64'hFFFF_FFFF_FFFF_FFF5);
    check("bounce_press_cycle", pressAt[1], 10);
    check("bounce_press_count", pressCnt[1], 1);
    check("bounce_release_count", releaseCnt[1], 0);
    settle();

    // Release commits at cycle 46, exactly where a fourth repeat would have landed.
    observe(60, 4'b1000, 64'h0000_00FF_FFFF_FFFF);
    check("long_press_cycle", pressAt[0], 6);
    check("long_cycle", longAt[0], 26);
    check("long_count", longCnt[0], 1);
    check("repeat_count", repeatCnt[0], 3);
    if (repeatAt.size() >= 3) begin
      check("repeat_first", repeatAt[0], 31);
      check("repeat_second", repeatAt[1], 36);
      check("repeat_third", repeatAt[2], 41);
    end
    check("long_release_cycle", releaseAt[0], 46);
    check("long_release_count", releaseCnt[0], 1);
    check("pulse_exclusive", vio, 0);
    settle();

    observe(12, 4'b1010, 64'hFFF);
    check("simul_press0_cycle", pressAt[0], 6);
    check("simul_press2_cycle", pressAt[2], 6);
    check("simul_any_count", anyCnt, 1);
    check("simul_press1_count", pressCnt[1], 0);
    settle();

    observe(30, 4'b0001, '1);
    check("hold3_long_cycle", longAt[3], 26);
    reset = 1'b0;
    #1;
    checkOutput("reset_mid_hold_async", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_mid_hold_quiet", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    reset = 1'b1;
    observe(10, 4'b0001, '1);
    check("after_reset_press_cycle", pressAt[3], 6);
    check("after_reset_release_count", releaseCnt[3], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
